// File: rtl/bram_add_pkg.sv
// Shared types and constants for the BRAM add engine: sequencer states and
// host memory-select codes.
package bram_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } add_state_e;

  localparam logic [1:0] HOST_SEL_A    = 2'd0;
  localparam logic [1:0] HOST_SEL_B    = 2'd1;
  localparam logic [1:0] HOST_SEL_C    = 2'd2;
  localparam logic [1:0] HOST_SEL_NONE = 2'd3;

endpackage

// File: rtl/bram_add_engine_sp_bram.sv
// Single-port RAM with registered read; the array carries no reset so it maps
// onto block RAM. Output holds its value on writes and idle cycles.
module sp_bram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= din;
      else    dout        <= mem_q[addr];
    end
  end

endmodule

// File: rtl/bram_add_engine.sv
// Element-wise C[i] = A[i] + B[i] engine over three single-port RAMs, with a
// host access port that owns the RAMs whenever the sequencer is not busy.
module bram_add_engine
  import bram_add_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [1:0]        host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic [DATA_W-1:0] host_dout,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              sat,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   ovf_cnt
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  add_state_e        state_q, state_d;
  logic [ADDR_W:0]   len_q, rd_idx_q, ovf_q, len_clamp;
  logic              sat_q, done_q, start_acc, eng_rd, busy_w;
  logic              vld_p1_q, carry_p1;
  logic [ADDR_W-1:0] idx_p1_q, ab_addr, c_addr;
  logic [DATA_W-1:0] a_dout, b_dout, c_dout, wr_data_p1, c_din;
  logic              rd_pend_q;
  logic [1:0]        rd_sel_q;
  logic [DATA_W-1:0] hold_q, rd_mux;
  logic              host_acc, a_en, b_en, ab_we, c_en, c_we;

  // Returns {carry, stored value}; saturation only applies on carry-out.
  function automatic logic [DATA_W:0] add_sat(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic              s);
    logic [DATA_W:0] sum;
    sum     = {1'b0, a} + {1'b0, b};
    add_sat = {sum[DATA_W], (s && sum[DATA_W]) ? {DATA_W{1'b1}} : sum[DATA_W-1:0]};
  endfunction

  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign start_acc = (state_q == S_IDLE) && !done_q && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_acc) state_d = (len_clamp == '0) ? S_DONE : S_RUN;
      S_RUN:   if (rd_idx_q == len_q - ONE_L) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // done is registered off the DONE state, so busy stays up through that cycle.
  always_comb begin
    eng_rd = (state_q == S_RUN);
    busy_w = (state_q != S_IDLE) || done_q;
  end

  assign busy    = busy_w;
  assign done    = done_q;
  assign ovf_cnt = ovf_q;

  // Stage p0 -> p1: read issue to write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_q  <= '0;
      vld_p1_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= '0;
      rd_pend_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_idx_q  <= eng_rd ? rd_idx_q + ONE_L : '0;
      vld_p1_q  <= eng_rd;
      done_q    <= (state_q == S_DONE);
      if (start_acc)                ovf_q <= '0;
      else if (vld_p1_q && carry_p1) ovf_q <= ovf_q + ONE_L;
      rd_pend_q <= host_en && !host_we;
      if (rd_pend_q) hold_q <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc) begin
      len_q <= len_clamp;
      sat_q <= sat;
    end
    idx_p1_q <= rd_idx_q[ADDR_W-1:0];
    if (host_en && !host_we) rd_sel_q <= busy_w ? HOST_SEL_NONE : host_sel;
  end

  assign {carry_p1, wr_data_p1} = add_sat(a_dout, b_dout, sat_q);

  always_comb begin
    rd_mux = '0;
    unique case (rd_sel_q)
      HOST_SEL_A: rd_mux = a_dout;
      HOST_SEL_B: rd_mux = b_dout;
      HOST_SEL_C: rd_mux = c_dout;
      default:    rd_mux = '0;
    endcase
  end

  assign host_dout = rd_pend_q ? rd_mux : hold_q;

  assign host_acc = host_en && !busy_w;
  assign a_en     = busy_w ? eng_rd : (host_acc && host_sel == HOST_SEL_A);
  assign b_en     = busy_w ? eng_rd : (host_acc && host_sel == HOST_SEL_B);
  assign ab_we    = !busy_w && host_we;
  assign ab_addr  = busy_w ? rd_idx_q[ADDR_W-1:0] : host_addr;
  assign c_en     = busy_w ? vld_p1_q : (host_acc && host_sel == HOST_SEL_C);
  assign c_we     = busy_w ? 1'b1 : host_we;
  assign c_addr   = busy_w ? idx_p1_q : host_addr;
  assign c_din    = busy_w ? wr_data_p1 : host_din;

  sp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_a (
    .clk(clk), .en(a_en), .we(ab_we), .addr(ab_addr), .din(host_din), .dout(a_dout)
  );

  sp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_b (
    .clk(clk), .en(b_en), .we(ab_we), .addr(ab_addr), .din(host_din), .dout(b_dout)
  );

  sp_bram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_c (
    .clk(clk), .en(c_en), .we(c_we), .addr(c_addr), .din(c_din), .dout(c_dout)
  );

endmodule

// File: tb/tb_bram_add_engine.sv
// Self-checking bench for bram_add_engine: table vectors, directed corner
// sequences and randomized runs against an array-based reference model.
module tb_bram_add_engine;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              host_en, host_we;
  logic [1:0]        host_sel;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_din, host_dout;
  logic              start;
  logic [ADDR_W:0]   len;
  logic              sat;
  logic              busy, done;
  logic [ADDR_W:0]   ovf_cnt;

  int nvec = 0;
  int nmis = 0;
  int ma [DEPTH];
  int mb [DEPTH];
  int mc [DEPTH];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
  } vec_t;

  always #5 clk = ~clk;

  bram_add_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .host_en(host_en), .host_we(host_we),
    .host_sel(host_sel), .host_addr(host_addr), .host_din(host_din),
    .host_dout(host_dout), .start(start), .len(len), .sat(sat),
    .busy(busy), .done(done), .ovf_cnt(ovf_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All host tasks are entered at a falling edge and return at a falling edge.
  task automatic host_write(input int sel, input int addr, input int data);
    host_en = 1'b1; host_we = 1'b1; host_sel = sel[1:0];
    host_addr = addr[ADDR_W-1:0]; host_din = data[DATA_W-1:0];
    @(negedge clk);
    host_en = 1'b0; host_we = 1'b0;
    if (sel == 0) ma[addr] = data & 16'hFFFF;
    if (sel == 1) mb[addr] = data & 16'hFFFF;
    if (sel == 2) mc[addr] = data & 16'hFFFF;
  endtask

  task automatic host_read(input int sel, input int addr, output logic [DATA_W-1:0] d);
    host_en = 1'b1; host_we = 1'b0; host_sel = sel[1:0]; host_addr = addr[ADDR_W-1:0];
    @(negedge clk);
    host_en = 1'b0;
    d = host_dout;
  endtask

  // Reference: element-wise sum over the clamped length; returns carry count.
  function automatic int model_run(input int n, input bit s);
    int cnt = 0;
    int m = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < m; i++) begin
      int sum = ma[i] + mb[i];
      if (sum > 65535) begin
        cnt++;
        mc[i] = s ? 65535 : sum - 65536;
      end else begin
        mc[i] = sum;
      end
    end
    return cnt;
  endfunction

  task automatic run(input string tag, input int n, input bit s);
    int j = 0;
    int exp_j;
    exp_j = ((n > DEPTH) ? DEPTH : n) + 2;
    start = 1'b1; len = n[ADDR_W:0]; sat = s;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, busy, 1'b1);
    while (!done && j < 600) begin
      @(negedge clk);
      j++;
    end
    check({tag, "_done_latency"}, done ? j : -1, exp_j);
    @(negedge clk);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_ovf_cnt"}, ovf_cnt, model_run(n, s));
  endtask

  task automatic check_c(input string tag, input int from, input int to);
    logic [DATA_W-1:0] d;
    for (int i = from; i <= to; i++) begin
      host_read(2, i, d);
      check(tag, d, mc[i]);
    end
  endtask

  initial begin
    vec_t tbl[8];
    logic [DATA_W-1:0] d;
    int j;
    int n;
    bit s;
    bit done_seen;

    tbl[0] = '{16'hFFFF, 16'h0002, 16'h0001, 16'hFFFF};
    tbl[1] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
    tbl[2] = '{16'h1234, 16'h1111, 16'h2345, 16'h2345};
    tbl[3] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFF};
    tbl[4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    tbl[7] = '{16'h8001, 16'h7FFF, 16'h0000, 16'hFFFF};

    rst_n = 1'b0; host_en = 1'b0; host_we = 1'b0; host_sel = 2'd0;
    host_addr = '0; host_din = '0; start = 1'b0; len = '0; sat = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_ovf", ovf_cnt, 0);
    check("reset_dout", host_dout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-fill the first 32 words so later runs start from known contents.
    for (int i = 0; i < 32; i++) begin
      host_write(0, i, 0); host_write(1, i, 0); host_write(2, i, 0);
    end

    // A[i] = i, B[i] = 2i.
    for (int i = 0; i < 10; i++) begin
      host_write(0, i, i);
      host_write(1, i, 2 * i);
    end
    run("basic", 10, 1'b0);
    for (int i = 0; i < 10; i++) begin
      host_read(2, i, d);
      check("basic_c_3i", d, 3 * i);
    end
    check("basic_ovf_zero", ovf_cnt, 0);

    // Carry vectors in both modes.
    for (int i = 0; i < 8; i++) begin
      host_write(0, i, tbl[i].a);
      host_write(1, i, tbl[i].b);
    end
    run("tbl_wrap", 8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      host_read(2, i, d);
      check("tbl_wrap_c", d, tbl[i].exp_wrap);
    end
    run("tbl_sat", 8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      host_read(2, i, d);
      check("tbl_sat_c", d, tbl[i].exp_sat);
    end

    // Memory select 3: reads return 0, writes go nowhere.
    host_write(3, 0, 16'h5555);
    host_read(3, 0, d);
    check("sel_none_read", d, 0);
    check_c("sel_none_c_intact", 0, 0);

    // len = 0: one busy-only cycle, then done, no write.
    host_write(2, 0, 16'hDEAD);
    start = 1'b1; len = '0; sat = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy_c1", busy, 1'b1);
    check("len0_done_c1", done, 1'b0);
    @(negedge clk);
    check("len0_busy_c2", busy, 1'b1);
    check("len0_done_c2", done, 1'b1);
    @(negedge clk);
    check("len0_busy_c3", busy, 1'b0);
    check("len0_done_c3", done, 1'b0);
    check("len0_ovf", ovf_cnt, 0);
    host_read(2, 0, d);
    check("len0_c_unchanged", d, 16'hDEAD);

    // Random short runs.
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 40);
      s = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        host_write(0, i, $urandom_range(0, 65535));
        host_write(1, i, $urandom_range(0, 65535));
      end
      run("rand", n, s);
      check_c("rand_c", 0, n - 1);
    end

    // len above DEPTH clamps to the full memory.
    for (int i = 0; i < DEPTH; i++) begin
      host_write(0, i, $urandom_range(0, 65535));
      host_write(1, i, $urandom_range(0, 65535));
    end
    run("clamp", 300, 1'($urandom_range(0, 1)));
    check_c("clamp_c", 0, DEPTH - 1);

    // Host write, host read and a second start while busy are all ignored.
    start = 1'b1; len = 9'd20; sat = 1'b0;
    @(negedge clk);
    start = 1'b0;
    host_en = 1'b1; host_we = 1'b1; host_sel = 2'd0; host_addr = 8'd5;
    host_din = 16'(~ma[5]);
    @(negedge clk);
    host_en = 1'b1; host_we = 1'b0; start = 1'b1; len = 9'd3;
    @(negedge clk);
    host_en = 1'b0; start = 1'b0;
    check("busy_host_read_zero", host_dout, 0);
    j = 2;
    while (!done && j < 100) begin
      @(negedge clk);
      j++;
    end
    check("busy_done_latency", done ? j : -1, 22);
    @(negedge clk);
    check("busy_fall", busy, 1'b0);
    check("busy_ovf", ovf_cnt, model_run(20, 1'b0));
    repeat (3) @(negedge clk);
    check("busy_no_rerun", busy, 1'b0);
    host_read(0, 5, d);
    check("busy_a5_kept", d, ma[5]);
    check_c("busy_c", 0, 19);

    // Reset during a len = 20 run, after three results are written.
    for (int i = 0; i < 20; i++) begin
      host_write(0, i, i + 1);
      host_write(1, i, 16'h0100);
      host_write(2, i, 16'hC000 + i);
    end
    start = 1'b1; len = 9'd20; sat = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy_low", busy, 1'b0);
    check("rst_done_low", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("rst_no_done", done_seen, 1'b0);
    check("rst_ovf", ovf_cnt, 0);
    for (int i = 0; i < 3; i++) mc[i] = ma[i] + mb[i];
    check_c("rst_c_partial", 0, 19);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/bram_add_engine.md
# bram_add_engine

Parametrised successor to the single-port 16-bit BRAM wrapper. Holds two operand memories (A, B) and a result memory (C), all inferred single-port block RAMs. The host loads A and B through a shared access port. On `start`, an internal pipelined sequencer computes C[i] = A[i] + B[i] for i = 0..len-1, wrapping or saturating per element, and counts overflows. The block sits between the host register interface and downstream consumers of C.

## Interface
- `DATA_W`, 16: element width, unsigned.
- `ADDR_W`, 8: address width.
- `DEPTH`, 2**ADDR_W: words per memory; must be ≤ 2**ADDR_W.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_en` in 1: host access strobe.
- `host_we` in 1: host write enable; 1 = write, 0 = read.
- `host_sel` in 2: memory select; 0 = A, 1 = B, 2 = C, 3 = none (read returns 0, write dropped).
- `host_addr` in ADDR_W: host word address.
- `host_din` in DATA_W: host write data.
- `host_dout` out DATA_W: host read data, registered.
- `start` in 1: single-cycle pulse that launches a run.
- `len` in ADDR_W+1: element count, 0..DEPTH; values above DEPTH clamp to DEPTH.
- `sat` in 1: 1 = saturate to all-ones on carry, 0 = wrap modulo 2**DATA_W.
- `busy` out 1: high while a run is in progress.
- `done` out 1: one-cycle pulse when a run completes.
- `ovf_cnt` out ADDR_W+1: number of elements with carry-out in the last run.

## Operation
- States are IDLE, RUN, DRAIN, DONE.
- IDLE:
  - Host accesses are serviced.
  - `start` latches `len` (clamped), `sat`, and clears `ovf_cnt`.
  - With len > 0 the FSM goes to RUN. With len = 0 it goes directly to DONE and no write occurs.
- RUN:
  - Read index `rd_idx` runs 0..len-1, one per cycle, driving the A and B addresses.
  - When `rd_idx` = len-1 is issued, the FSM goes to DRAIN.
- DRAIN: one cycle for the last write, then DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Write stage:
  - Runs one cycle after each read.
  - Uses a delayed index `wr_idx` and a valid bit.
  - Sum = A + B in DATA_W+1 bits. Carry = sum[DATA_W].
  - Written value = sat & carry ? all-ones : sum[DATA_W-1:0].
  - `ovf_cnt` increments on each carry, in both modes.
- While busy:
  - Host writes are dropped and host reads return 0.
  - `start` is ignored.
- Memory ports are muxed between host and engine by `busy`. There is never a simultaneous host/engine access to the same RAM.
- Reset:
  - `busy` = 0, `done` = 0, `ovf_cnt` = 0, `host_dout` = 0, FSM = IDLE, pipeline valid = 0.
  - RAM contents are not reset.
  - Reset mid-run aborts immediately. C keeps any partially written results. No `done` is issued.

## Timing
- Host read: `host_dout` is valid on the cycle after the `host_en` & !`host_we` edge, and holds until the next read.
- Host write: takes effect at the `host_en` edge.
- Run of N > 0, with `start` sampled at edge 0:
  - `busy` rises after edge 0.
  - Reads are issued at edges 1..N.
  - C writes occur at edges 2..N+1.
  - `done` is high for the cycle after edge N+2; `busy` falls with it.
  - Total is N+3 cycles from start to return to IDLE.
- N = 0: `busy` is high one cycle, then `done`.
- The first host read of C after `done` returns final data.
- `busy` and `done` are both high in the DONE cycle.

## Structure
- Package `bram_add_pkg`: state enum `add_state_e`, `HOST_SEL_A/B/C/NONE` constants.
- Sub-module `sp_bram`:
  - Parameters `DATA_W`, `ADDR_W`, `DEPTH`.
  - Ports en, we, addr, din, dout with registered read.
  - Instantiated three times (A, B, C).
  - Must infer block RAM and have no reset on the array.

## Test plan
- Load A[i] = i, B[i] = 2i for i = 0..9; start with len = 10, sat = 0.
  - `done` arrives exactly 12 cycles after start.
  - C[i] reads back 3i; `ovf_cnt` = 0.
- Set A[0] = 0xFFFF, B[0] = 0x0002, A[1] = 0x8000, B[1] = 0x8000; run len = 2.
  - sat = 0: C = {0x0001, 0x0000}, `ovf_cnt` = 2.
  - sat = 1: C = {0xFFFF, 0xFFFF}, `ovf_cnt` = 2.
- len = 0: `busy` is high for 1 cycle, then `done`; C is unchanged (preloaded 0xDEAD stays).
- len = 300 with ADDR_W = 8: clamps to 256, so `done` arrives at start + 258 and C[255] is correct.
- During a run: a host write to A[5] and a second `start` are both ignored; a host read returns 0.
- Assert `rst_n` low at cycle 5 of a len = 20 run.
  - Immediately `busy` = 0 and `done` never pulses.
  - C[0..2] hold new sums; C[3..19] hold their old values.
